vram_wr_arb: RTL and testbench
==============================

VRAM_WR_ARB -- requirements
Module: vram_wr_arb

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, CPU write FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter STARVE_MAX, default 4, maximum consecutive CPU grants while the loader is waiting.
REQ-003 Clock and reset: one clock, CLK; reset RESET is synchronous and active-high.
REQ-004 CLK  in  1  system/pixel clock; all inputs synchronous to it.
REQ-005 RESET  in  1  synchronous active-high reset.
REQ-006 CPU_CS_n  in  1  CPU video-memory write strobe, active-low level.
REQ-007 CPU_A  in  17  CPU byte address into video RAM.
REQ-008 CPU_D  in  8  CPU write data byte.
REQ-009 CPU_WAIT_n  out  1  low = FIFO full, CPU must stall.
REQ-010 LD_VALID  in  1  loader (UART) word write request.
REQ-011 LD_READY  out  1  loader request accepted when LD_VALID and LD_READY are both high on a rising CLK edge.
REQ-012 LD_ADDR  in  16  loader word address.
REQ-013 LD_DATA  in  16  loader word data.
REQ-014 VWE_n  out  1  video RAM write enable, active-low, one-cycle pulse.
REQ-015 VADDR  out  16  video RAM word address.
REQ-016 VDATA  out  16  video RAM write data.
REQ-017 VLE_n / VHE_n  out  1 each  low/high byte enables, active-low.
REQ-018 FIFO_LEVEL  out  5  current CPU FIFO occupancy.
REQ-019 OVF  out  1  sticky flag: a CPU write was dropped.

Function
REQ-020 Falling-edge detect on CPU_CS_n (previous-sample register, reset value 1) shall push {CPU_A, CPU_D} into the FIFO on the cycle after the edge is sampled; a held-low strobe shall push once only.
REQ-021 A push arriving when the FIFO is full shall be dropped and set OVF; only RESET clears OVF.
REQ-022 A simultaneous push and pop shall leave FIFO_LEVEL unchanged, and both operations shall take effect.
REQ-023 CPU_WAIT_n shall be low exactly while FIFO_LEVEL == FIFO_DEPTH.
REQ-024 FSM states: IDLE, WR_CPU, WR_LD. WR_CPU and WR_LD shall each last one cycle and then return to IDLE, so at most one write is issued per two cycles.
REQ-025 In IDLE, LD_READY = FIFO empty OR starve_cnt == STARVE_MAX; LD_READY shall not depend on LD_VALID, and shall be 0 outside IDLE.
REQ-026 In IDLE, loader handshake -> WR_LD next cycle; otherwise a non-empty FIFO -> pop and WR_CPU next cycle; otherwise remain in IDLE.
REQ-027 In WR_CPU and WR_LD, VWE_n shall be 0 and VADDR/VDATA/VLE_n/VHE_n shall be valid; VWE_n shall be 1 in IDLE.
REQ-028 Write latency: loader handshake edge or FIFO pop edge -> VWE_n low in the immediately following cycle.
REQ-029 CPU write mapping: VADDR=A[16:1], VDATA={D,D}, VLE_n=A[0], VHE_n=~A[0].
REQ-030 Loader write mapping: VADDR=LD_ADDR, VDATA=LD_DATA, VLE_n=VHE_n=0.
REQ-031 VADDR, VDATA and the byte enables shall hold their last values in IDLE.
REQ-032 starve_cnt: increment (saturating at STARVE_MAX) on each CPU grant with LD_VALID high; clear on a loader grant or whenever LD_VALID is low in IDLE.
REQ-033 FIFO pointers shall wrap modulo FIFO_DEPTH; FIFO_LEVEL is a FIFO_DEPTH+1-state counter.

Reset
REQ-034 On RESET: state=IDLE, FIFO flushed, FIFO_LEVEL=0, starve_cnt=0, OVF=0, VWE_n=1, VLE_n=VHE_n=1, VADDR=0, VDATA=0, CPU_WAIT_n=1, edge register=1.
REQ-035 RESET asserted during WR_CPU/WR_LD shall abort the write: VWE_n=1 in the next cycle, and the popped entry is lost.
REQ-036 LD_READY shall be 0 during reset; it shall be 1 in the first cycle after release because the FIFO is empty.

Structure
REQ-037 Shared package vram_arb_pkg shall hold the FSM state encoding, the FIFO entry width (25) and the default parameters.
REQ-038 One sub-module, arb_fifo: synchronous FIFO with push/pop/full/empty/level; the arbiter FSM, edge detect and output registers stay in vram_wr_arb.

Verification
REQ-039 CPU write A=17'h00013, D=8'hA5, loader idle -> one VWE_n pulse with VADDR=16'h0009, VDATA=16'hA5A5, VLE_n=1, VHE_n=0.
REQ-040 Loader LD_ADDR=16'h1234, LD_DATA=16'hBEEF, FIFO empty -> LD_READY=1, handshake, next cycle VWE_n=0 with both byte enables low.
REQ-041 Five CPU strobes back-to-back with no pops possible (FIFO_DEPTH=4) -> CPU_WAIT_n low at level 4, fifth write dropped, OVF=1.
REQ-042 Loader held valid with a continuous CPU stream -> exactly 4 CPU writes, then 1 loader write, repeating.
REQ-043 Simultaneous push and pop at level 2 -> level remains 2 and data order is preserved.
REQ-044 RESET asserted in WR_LD -> VWE_n=1 next cycle, level 0, OVF 0; LD_READY=1 after release.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and defaults for the video RAM write
// arbiter and its CPU write FIFO.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_CPU = 2'd1,
    ST_WR_LD  = 2'd2
  } arb_state_e;

  localparam int ENTRY_W        = 25;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_STARVE_MAX = 4;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } cpu_entry_t;

endpackage

// File: rtl/arb_fifo.sv
// arb_fifo: synchronous FIFO holding pending CPU byte writes; a push
// into a full FIFO is refused unless a pop frees a slot that cycle.
module arb_fifo
  import vram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_din,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_dout,
  output logic               o_full,
  output logic               o_empty,
  output logic [4:0]         o_level,
  output logic               o_drop
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] LV_FULL = 5'(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wr;
  logic [PW-1:0]      r_rd;
  logic [4:0]         r_level;
  logic               w_pop_ok;
  logic               w_push_ok;

  assign o_full    = (r_level == LV_FULL);
  assign o_empty   = (r_level == 5'd0);
  assign o_level   = r_level;
  assign o_dout    = r_mem[r_rd];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_drop    = i_push & ~w_push_ok;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= 5'd0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok)  r_rd <= r_rd + 1'b1;
      if (w_push_ok && !w_pop_ok) begin
        r_level <= r_level + 5'd1;
      end else if (w_pop_ok && !w_push_ok) begin
        r_level <= r_level - 5'd1;
      end
    end
  end

endmodule

// File: rtl/vram_wr_arb.sv
// vram_wr_arb: merges buffered CPU byte writes and loader word writes
// onto one video RAM write port, bounding how long the loader waits.
module vram_wr_arb
  import vram_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CPU_CS_n,
  input  logic [16:0] CPU_A,
  input  logic [7:0]  CPU_D,
  output logic        CPU_WAIT_n,
  input  logic        LD_VALID,
  output logic        LD_READY,
  input  logic [15:0] LD_ADDR,
  input  logic [15:0] LD_DATA,
  output logic        VWE_n,
  output logic [15:0] VADDR,
  output logic [15:0] VDATA,
  output logic        VLE_n,
  output logic        VHE_n,
  output logic [4:0]  FIFO_LEVEL,
  output logic        OVF
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

  arb_state_e         r_state;
  arb_state_e         w_next;
  logic               r_cs_prev;
  logic               w_fall;
  logic [SW-1:0]      r_starve;
  logic               r_ovf;
  logic [15:0]        r_vaddr;
  logic [15:0]        r_vdata;
  logic               r_vle_n;
  logic               r_vhe_n;
  logic [ENTRY_W-1:0] w_din;
  logic [ENTRY_W-1:0] w_dout;
  cpu_entry_t         w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;
  logic               w_idle;
  logic               w_ld_ready;
  logic               w_hs;
  logic               w_pop;
  logic               w_vwe_n;

  assign w_fall = r_cs_prev & ~CPU_CS_n;
  assign w_din  = {CPU_A, CPU_D};
  assign w_head = cpu_entry_t'(w_dout);

  arb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .i_push (w_fall),
    .i_din  (w_din),
    .i_pop  (w_pop),
    .o_dout (w_dout),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_level(FIFO_LEVEL),
    .o_drop (w_drop)
  );

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_hs)          w_next = ST_WR_LD;
        else if (!w_empty) w_next = ST_WR_CPU;
      end
      ST_WR_CPU, ST_WR_LD: w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  // Loader readiness must not look at LD_VALID, only at FIFO/starvation.
  always_comb begin
    w_idle     = (r_state == ST_IDLE);
    w_ld_ready = ~RESET & w_idle
               & (w_empty | (r_starve == STARVE_SAT));
    w_hs       = w_ld_ready & LD_VALID;
    w_pop      = w_idle & ~w_hs & ~w_empty;
    w_vwe_n    = w_idle;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cs_prev <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      r_cs_prev <= CPU_CS_n;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_starve <= '0;
    end else if (w_hs) begin
      r_starve <= '0;
    end else if (w_pop && LD_VALID) begin
      if (r_starve != STARVE_SAT) r_starve <= r_starve + 1'b1;
    end else if (w_idle && !LD_VALID) begin
      r_starve <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_vaddr <= 16'h0000;
      r_vdata <= 16'h0000;
      r_vle_n <= 1'b1;
      r_vhe_n <= 1'b1;
    end else if (w_hs) begin
      r_vaddr <= LD_ADDR;
      r_vdata <= LD_DATA;
      r_vle_n <= 1'b0;
      r_vhe_n <= 1'b0;
    end else if (w_pop) begin
      r_vaddr <= w_head.addr[16:1];
      r_vdata <= {w_head.data, w_head.data};
      r_vle_n <= w_head.addr[0];
      r_vhe_n <= ~w_head.addr[0];
    end
  end

  assign VWE_n      = w_vwe_n;
  assign VADDR      = r_vaddr;
  assign VDATA      = r_vdata;
  assign VLE_n      = r_vle_n;
  assign VHE_n      = r_vhe_n;
  assign LD_READY   = w_ld_ready;
  assign CPU_WAIT_n = ~w_full;
  assign OVF        = r_ovf;

endmodule

// File: tb/tb_vram_wr_arb.sv
// tb_vram_wr_arb: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vram_wr_arb;

  localparam int DEPTH = 4;
  localparam int SMAX  = 4;

  logic        CLK;
  logic        RESET;
  logic        CPU_CS_n;
  logic [16:0] CPU_A;
  logic [7:0]  CPU_D;
  logic        CPU_WAIT_n;
  logic        LD_VALID;
  logic        LD_READY;
  logic [15:0] LD_ADDR;
  logic [15:0] LD_DATA;
  logic        VWE_n;
  logic [15:0] VADDR;
  logic [15:0] VDATA;
  logic        VLE_n;
  logic        VHE_n;
  logic [4:0]  FIFO_LEVEL;
  logic        OVF;

  vram_wr_arb #(
    .FIFO_DEPTH(DEPTH),
    .STARVE_MAX(SMAX)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .CPU_CS_n  (CPU_CS_n),
    .CPU_A     (CPU_A),
    .CPU_D     (CPU_D),
    .CPU_WAIT_n(CPU_WAIT_n),
    .LD_VALID  (LD_VALID),
    .LD_READY  (LD_READY),
    .LD_ADDR   (LD_ADDR),
    .LD_DATA   (LD_DATA),
    .VWE_n     (VWE_n),
    .VADDR     (VADDR),
    .VDATA     (VDATA),
    .VLE_n     (VLE_n),
    .VHE_n     (VHE_n),
    .FIFO_LEVEL(FIFO_LEVEL),
    .OVF       (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: pending CPU writes in queues, one busy flag for
  // the one-cycle write slot that follows every grant.
  int   mq_a[$];
  int   mq_d[$];
  bit   m_valid = 0;
  bit   m_busy;
  int   m_starve;
  bit   m_prev;
  bit   m_ovf;
  bit   m_vwe_n;
  bit   [15:0] m_vaddr;
  bit   [15:0] m_vdata;
  bit   m_vle_n;
  bit   m_vhe_n;
  bit   m_pp2 = 0;
  bit   pp2_seen = 0;

  always @(posedge CLK) begin
    bit hs;
    bit pop;
    bit fall;
    bit rdy;
    int a;
    int d;
    m_pp2 = 0;
    if (RESET) begin
      mq_a.delete();
      mq_d.delete();
      m_busy   = 0;
      m_starve = 0;
      m_prev   = 1;
      m_ovf    = 0;
      m_vwe_n  = 1;
      m_vaddr  = 0;
      m_vdata  = 0;
      m_vle_n  = 1;
      m_vhe_n  = 1;
    end else begin
      rdy  = !m_busy && (mq_a.size() == 0 || m_starve == SMAX);
      hs   = rdy && LD_VALID;
      pop  = !m_busy && !hs && mq_a.size() > 0;
      fall = m_prev && !CPU_CS_n;
      m_prev = CPU_CS_n;
      m_pp2 = pop && fall && mq_a.size() == 2;
      if (m_busy) begin
        m_busy  = 0;
        m_vwe_n = 1;
      end else if (hs) begin
        m_busy   = 1;
        m_vwe_n  = 0;
        m_vaddr  = LD_ADDR;
        m_vdata  = LD_DATA;
        m_vle_n  = 0;
        m_vhe_n  = 0;
        m_starve = 0;
      end else if (pop) begin
        a = mq_a.pop_front();
        d = mq_d.pop_front();
        m_busy  = 1;
        m_vwe_n = 0;
        m_vaddr = 16'(a / 2);
        m_vdata = 16'(d * 257);
        m_vle_n = (a % 2) == 1;
        m_vhe_n = (a % 2) == 0;
        if (LD_VALID) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        else          m_starve = 0;
      end else if (!LD_VALID) begin
        m_starve = 0;
      end
      if (fall) begin
        if (mq_a.size() < DEPTH) begin
          mq_a.push_back(int'(CPU_A));
          mq_d.push_back(int'(CPU_D));
        end else begin
          m_ovf = 1;
        end
      end
    end
    m_valid = 1;
  end

  always @(negedge CLK) begin
    bit e_rdy;
    if (m_valid) begin
      e_rdy = !RESET && !m_busy && (mq_a.size() == 0 || m_starve == SMAX);
      chk("VWE_n",      32'(VWE_n),      32'(m_vwe_n));
      chk("VADDR",      32'(VADDR),      32'(m_vaddr));
      chk("VDATA",      32'(VDATA),      32'(m_vdata));
      chk("VLE_n",      32'(VLE_n),      32'(m_vle_n));
      chk("VHE_n",      32'(VHE_n),      32'(m_vhe_n));
      chk("FIFO_LEVEL", 32'(FIFO_LEVEL), 32'(mq_a.size()));
      chk("CPU_WAIT_n", 32'(CPU_WAIT_n), 32'(mq_a.size() != DEPTH));
      chk("LD_READY",   32'(LD_READY),   32'(e_rdy));
      chk("OVF",        32'(OVF),        32'(m_ovf));
      if (m_pp2) begin
        pp2_seen = 1;
        chk("push_pop_lvl2", 32'(FIFO_LEVEL), 32'd2);
      end
    end
  end

  bit  rec_en = 0;
  bit  cnt_en = 0;
  int  pulses = 0;
  bit  wait_low_seen = 0;
  byte seq[$];

  always @(negedge CLK) begin
    if (cnt_en && VWE_n === 1'b0) pulses++;
    if (rec_en && VWE_n === 1'b0) begin
      if (VLE_n === 1'b0 && VHE_n === 1'b0) seq.push_back(8'h4C);
      else                                  seq.push_back(8'h43);
    end
    if (FIFO_LEVEL == 5'd4 && CPU_WAIT_n === 1'b0) wait_low_seen = 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    string pat;
    int    k;
    bit    low;
    bit    found;
    pat = "CCCCLCCCCLCCCCL";
    RESET    = 1'b1;
    CPU_CS_n = 1'b1;
    CPU_A    = '0;
    CPU_D    = '0;
    LD_VALID = 1'b0;
    LD_ADDR  = '0;
    LD_DATA  = '0;
    repeat (3) tick();
    @(negedge CLK);
    chk("rst_ld_ready", 32'(LD_READY), 32'd0);
    chk("rst_vwe_n",    32'(VWE_n),    32'd1);
    chk("rst_vaddr",    32'(VADDR),    32'd0);
    chk("rst_vdata",    32'(VDATA),    32'd0);
    chk("rst_vle_vhe",  32'({VLE_n, VHE_n}), 32'd3);
    chk("rst_level",    32'(FIFO_LEVEL), 32'd0);
    chk("rst_wait_n",   32'(CPU_WAIT_n), 32'd1);
    chk("rst_ovf",      32'(OVF),      32'd0);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    chk("ld_ready_after_rst", 32'(LD_READY), 32'd1);

    // single CPU write, loader idle
    tick();
    CPU_A    = 17'h00013;
    CPU_D    = 8'hA5;
    CPU_CS_n = 1'b0;
    tick();
    CPU_CS_n = 1'b1;
    tick();
    @(negedge CLK);
    chk("cpu_vwe_n", 32'(VWE_n), 32'd0);
    chk("cpu_vaddr", 32'(VADDR), 32'h0009);
    chk("cpu_vdata", 32'(VDATA), 32'hA5A5);
    chk("cpu_vle_n", 32'(VLE_n), 32'd1);
    chk("cpu_vhe_n", 32'(VHE_n), 32'd0);
    tick();
    @(negedge CLK);
    chk("cpu_end_vwe_n", 32'(VWE_n), 32'd1);
    chk("idle_hold_vaddr", 32'(VADDR), 32'h0009);

    // held-low strobe gives one write only
    tick();
    cnt_en   = 1;
    CPU_A    = 17'h00002;
    CPU_D    = 8'h3C;
    CPU_CS_n = 1'b0;
    repeat (6) tick();
    CPU_CS_n = 1'b1;
    repeat (4) tick();
    cnt_en = 0;
    chk("held_strobe_once", 32'(pulses), 32'd1);

    // loader write with FIFO empty
    @(negedge CLK);
    chk("ld_ready_empty", 32'(LD_READY), 32'd1);
    tick();
    LD_VALID = 1'b1;
    LD_ADDR  = 16'h1234;
    LD_DATA  = 16'hBEEF;
    tick();
    LD_VALID = 1'b0;
    @(negedge CLK);
    chk("ld_vwe_n",     32'(VWE_n), 32'd0);
    chk("ld_vaddr",     32'(VADDR), 32'h1234);
    chk("ld_vdata",     32'(VDATA), 32'hBEEF);
    chk("ld_vle_vhe",   32'({VLE_n, VHE_n}), 32'd0);
    chk("ld_ready_busy", 32'(LD_READY), 32'd0);
    tick();
    tick();

    // loader held valid against a continuous CPU strobe stream
    rec_en = 1;
    k = 0;
    for (int i = 0; i < 62; i++) begin
      low = (i <= 20) ? (i % 2 == 0) : (i >= 23 && i % 2 == 1);
      if (low) begin
        CPU_A = 17'h00100 + 17'(k);
        CPU_D = 8'(k + 8'h10);
        k++;
      end
      CPU_CS_n = !low;
      LD_VALID = (i >= 1);
      LD_ADDR  = 16'h0100;
      LD_DATA  = 16'h5555;
      tick();
    end
    rec_en   = 0;
    CPU_CS_n = 1'b1;
    for (int j = 0; j < 15; j++) begin
      if (seq.size() > j) chk($sformatf("grant_%0d", j), 32'(seq[j]), 32'(pat[j]));
      else                chk($sformatf("grant_%0d", j), 32'd0, 32'(pat[j]));
    end
    @(negedge CLK);
    chk("ovf_sticky",    32'(OVF), 32'd1);
    chk("wait_low_seen", 32'(wait_low_seen), 32'd1);
    chk("pp2_seen",      32'(pp2_seen), 32'd1);

    // reset during a loader write slot
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge CLK);
      if (VWE_n === 1'b0 && VLE_n === 1'b0 && VHE_n === 1'b0) found = 1;
    end
    chk("ld_slot_found", 32'(found), 32'd1);
    #1;
    RESET    = 1'b1;
    LD_VALID = 1'b0;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("abort_vwe_n", 32'(VWE_n), 32'd1);
    chk("abort_level", 32'(FIFO_LEVEL), 32'd0);
    chk("abort_ovf",   32'(OVF), 32'd0);
    chk("abort_ld_ready", 32'(LD_READY), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("release_ld_ready", 32'(LD_READY), 32'd1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
